// File: rtl/maze_pkg.sv
// maze_pkg: shared grid geometry, RAM map addresses, direction and FSM encodings.
// Rev 1.0
`default_nettype none

package maze_pkg;

  localparam int GRID_DIM  = 8;
  localparam int CELL_W    = 6;
  localparam int NUM_CELLS = 64;
  localparam int SRC_ADDR  = 130;
  localparam int TGT_ADDR  = 131;

  localparam logic [7:0] PATH_VAL     = 8'h00;
  localparam logic [7:0] OBSTACLE_VAL = 8'hee;

  typedef enum logic [1:0] {
    DIR_E = 2'd0,
    DIR_W = 2'd1,
    DIR_S = 2'd2,
    DIR_N = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_RD_SRC     = 4'd1,
    ST_RD_SRC_W   = 4'd2,
    ST_RD_TGT     = 4'd3,
    ST_RD_TGT_W   = 4'd4,
    ST_EMIT       = 4'd5,
    ST_PROBE_REQ  = 4'd6,
    ST_PROBE_WAIT = 4'd7,
    ST_DONE       = 4'd8,
    ST_ERR        = 4'd9
  } state_t;

endpackage

`default_nettype wire

// File: rtl/route_walker_if.sv
// route_walker_if: RAM read port plus coordinate stream of the route walker.
// Rev 1.0
`default_nettype none

interface route_walker_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] address;
  logic                  cs;
  logic                  we;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [2:0]            out_x;
  logic [2:0]            out_y;
  logic                  out_last;

  modport master (
    output address, cs, we, out_valid, out_x, out_y, out_last,
    input  data_in, out_ready
  );

  modport slave (
    input  address, cs, we, out_valid, out_x, out_y, out_last,
    output data_in, out_ready
  );

endinterface

`default_nettype wire

// File: rtl/route_walker_neighbour_calc.sv
// neighbour_calc: neighbour cell index of cur in direction dir, and whether it stays on the grid.
// Rev 1.0
`default_nettype none

module neighbour_calc
  import maze_pkg::*;
#(
  parameter int ROW_LEN = 8
) (
  input  logic [CELL_W-1:0] cur,
  input  dir_t              dir,
  output logic [CELL_W-1:0] neighbour,
  output logic              in_grid
);

  logic [CELL_W-1:0] x;
  logic [CELL_W-1:0] y;

  always_comb begin
    x         = CELL_W'(cur % ROW_LEN);
    y         = CELL_W'(cur / ROW_LEN);
    neighbour = cur;
    in_grid   = 1'b0;
    // Edge tests use the column/row, so E/W never wrap into the adjacent row.
    case (dir)
      DIR_E: begin
        in_grid   = (x != CELL_W'(ROW_LEN - 1));
        neighbour = cur + CELL_W'(1);
      end
      DIR_W: begin
        in_grid   = (x != '0);
        neighbour = cur - CELL_W'(1);
      end
      DIR_S: begin
        in_grid   = (y != CELL_W'(ROW_LEN - 1));
        neighbour = cur + CELL_W'(ROW_LEN);
      end
      DIR_N: begin
        in_grid   = (y != '0);
        neighbour = cur - CELL_W'(ROW_LEN);
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/route_walker.sv
// route_walker: reads the routed map from RAM and streams the path from source to target.
// Rev 1.0
`default_nettype none

module route_walker #(
  parameter int                    GRID_DIM   = maze_pkg::GRID_DIM,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    SRC_ADDR   = maze_pkg::SRC_ADDR,
  parameter int                    TGT_ADDR   = maze_pkg::TGT_ADDR,
  parameter logic [DATA_WIDTH-1:0] PATH_VAL   = maze_pkg::PATH_VAL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  route_walker_if.master        bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [6:0]            path_len
);

  import maze_pkg::*;

  state_t                state;
  state_t                state_nxt;
  dir_t                  dir;
  dir_t                  probe_dir;
  dir_t                  sel_dir;
  logic [CELL_W-1:0]     src;
  logic [CELL_W-1:0]     tgt;
  logic [CELL_W-1:0]     cur;
  logic [CELL_W-1:0]     probe_nb;
  logic [CELL_W-1:0]     sel_nb;
  logic [NUM_CELLS-1:0]  visited;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [6:0]            len;
  logic                  err_r;
  logic [CELL_W-1:0]     nb [4];
  logic [3:0]            nb_ok;
  logic                  found;
  logic                  accept;
  logic                  is_last;

  generate
    for (genvar d = 0; d < 4; d++) begin : g_dir
      neighbour_calc #(
        .ROW_LEN (GRID_DIM)
      ) u_nc (
        .cur       (cur),
        .dir       (dir_t'(2'(d))),
        .neighbour (nb[d]),
        .in_grid   (nb_ok[d])
      );
    end
  endgenerate

  // First direction at or after dir that is on-grid and unvisited; skipped ones cost no cycle.
  always_comb begin
    found   = 1'b0;
    sel_dir = dir;
    sel_nb  = nb[0];
    for (int d = 0; d < 4; d++) begin
      if (!found && (2'(d) >= dir) && nb_ok[d] && !visited[nb[d]]) begin
        found   = 1'b1;
        sel_dir = dir_t'(2'(d));
        sel_nb  = nb[d];
      end
    end
  end

  assign accept  = (bus.data_in == PATH_VAL) || (probe_nb == tgt);
  assign is_last = (cur == tgt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr_hold;
    bus.cs        = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_x     = 3'd0;
    bus.out_y     = 3'd0;
    bus.out_last  = 1'b0;
    done          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RD_SRC;
      end
      ST_RD_SRC: begin
        bus.cs    = 1'b1;
        addr_nxt  = ADDR_WIDTH'(SRC_ADDR);
        state_nxt = ST_RD_SRC_W;
      end
      ST_RD_SRC_W: state_nxt = ST_RD_TGT;
      ST_RD_TGT: begin
        bus.cs    = 1'b1;
        addr_nxt  = ADDR_WIDTH'(TGT_ADDR);
        state_nxt = ST_RD_TGT_W;
      end
      ST_RD_TGT_W: state_nxt = ST_EMIT;
      ST_EMIT: begin
        bus.out_valid = 1'b1;
        bus.out_x     = cur[2:0];
        bus.out_y     = cur[5:3];
        bus.out_last  = is_last;
        if (bus.out_ready) begin
          if (is_last)            state_nxt = ST_DONE;
          else if (len == 7'd63)  state_nxt = ST_ERR;
          else                    state_nxt = ST_PROBE_REQ;
        end
      end
      ST_PROBE_REQ: begin
        if (found) begin
          bus.cs    = 1'b1;
          addr_nxt  = ADDR_WIDTH'(sel_nb);
          state_nxt = ST_PROBE_WAIT;
        end else begin
          state_nxt = ST_ERR;
        end
      end
      ST_PROBE_WAIT: begin
        if (accept)                  state_nxt = ST_EMIT;
        else if (probe_dir == DIR_N) state_nxt = ST_ERR;
        else                         state_nxt = ST_PROBE_REQ;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.address = addr_nxt;
  assign bus.we      = 1'b0;
  assign busy        = (state != ST_IDLE);
  assign err         = err_r;
  assign path_len    = len;

  always_ff @(posedge clk) begin
    if (!reset) begin
      src       <= '0;
      tgt       <= '0;
      cur       <= '0;
      probe_nb  <= '0;
      dir       <= DIR_E;
      probe_dir <= DIR_E;
      visited   <= '0;
      len       <= '0;
      err_r     <= 1'b0;
      addr_hold <= '0;
    end else begin
      addr_hold <= addr_nxt;
      if (state_nxt == ST_ERR) err_r <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_r   <= 1'b0;
            len     <= '0;
            visited <= '0;
          end
        end
        ST_RD_SRC_W: src <= bus.data_in[CELL_W-1:0];
        ST_RD_TGT_W: begin
          tgt          <= bus.data_in[CELL_W-1:0];
          cur          <= src;
          visited[src] <= 1'b1;
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            len <= len + 7'd1;
            dir <= DIR_E;
          end
        end
        ST_PROBE_REQ: begin
          probe_dir <= sel_dir;
          probe_nb  <= sel_nb;
        end
        ST_PROBE_WAIT: begin
          if (accept) begin
            cur               <= probe_nb;
            visited[probe_nb] <= 1'b1;
          end else if (probe_dir != DIR_N) begin
            dir <= dir_t'(probe_dir + 2'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_route_walker.sv
// tb_route_walker: directed and randomized walks checked against a grid-level path model.
// Rev 1.0
`default_nettype none

module tb_route_walker;
  import maze_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic       err;
  logic [6:0] path_len;

  route_walker_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  route_walker dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .path_len (path_len)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  always @(posedge clk) if (bus.cs) bus.data_in <= mem[bus.address];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int pk(input int x, input int y, input bit l);
    return (int'(l) << 6) | (y << 3) | x;
  endfunction

  int exp_q[$];
  bit exp_err;
  int exp_len;

  // Greedy walk over the grid using the documented direction order and acceptance rule.
  task automatic model(input int s, input int t);
    bit vis [64];
    int c, n, nx, ny, nbr;
    bit found;
    exp_q.delete();
    foreach (vis[i]) vis[i] = 1'b0;
    c = s; vis[c] = 1'b1; n = 0; exp_err = 1'b0;
    forever begin
      exp_q.push_back(pk(c % 8, c / 8, c == t));
      n++;
      if (c == t) break;
      if (n == 64) begin exp_err = 1'b1; break; end
      found = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (!found) begin
          nx = c % 8 + ((d == 0) ? 1 : (d == 1) ? -1 : 0);
          ny = c / 8 + ((d == 2) ? 1 : (d == 3) ? -1 : 0);
          if (nx >= 0 && nx < 8 && ny >= 0 && ny < 8) begin
            nbr = ny * 8 + nx;
            if (!vis[nbr] && (mem[nbr] == PATH_VAL || nbr == t)) begin
              found = 1'b1; c = nbr; vis[nbr] = 1'b1;
            end
          end
        end
      end
      if (!found) begin exp_err = 1'b1; break; end
    end
    exp_len = n;
  endtask

  int ready_mode = 0;
  int rcnt = 0;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rcnt++;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (rcnt % 4 == 3);
      endcase
    end
  end

  bit       mon_en = 1'b0;
  int       beats, addr8_hits, done_cnt;
  bit       prev_stall = 1'b0;
  logic [6:0] prev_out;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.cs && bus.address == 8'd8) addr8_hits++;
      if (done) done_cnt++;
      if (prev_stall) begin
        check_val("stall_valid", 32'(bus.out_valid), 32'd1);
        check_val("stall_data", 32'({bus.out_last, bus.out_y, bus.out_x}), 32'(prev_out));
      end
      if (bus.out_valid && bus.out_ready) begin
        check_val("beat_avail", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check_val("beat", 32'({bus.out_last, bus.out_y, bus.out_x}), 32'(exp_q.pop_front()));
        beats++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_out   = {bus.out_last, bus.out_y, bus.out_x};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 64; i++) mem[i] = v;
  endtask

  task automatic run_walk(input int s, input int t, input int poke_at, input bit chk_lat);
    int cyc, first, saw_len;
    bit timeout;
    mem[SRC_ADDR] = 8'(s);
    mem[TGT_ADDR] = 8'(t);
    model(s, t);
    beats = 0; addr8_hits = 0; done_cnt = 0;
    mon_en = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; first = -1; saw_len = -1; timeout = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      cyc++;
      if (first < 0 && bus.out_valid) first = cyc;
      if (done) saw_len = int'(path_len);
      start = (cyc == poke_at);
      if (!busy) begin timeout = 1'b0; break; end
    end
    start = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    check_val("timeout", 32'(timeout), 32'd0);
    check_val("err", 32'(err), 32'(exp_err));
    check_val("done_cnt", 32'(done_cnt), exp_err ? 32'd0 : 32'd1);
    if (!exp_err) check_val("path_len", 32'(saw_len), 32'(exp_len));
    check_val("beats", 32'(beats), 32'(exp_len));
    check_val("left", 32'(exp_q.size()), 32'd0);
    if (chk_lat) check_val("latency", 32'(first), 32'd5);
  endtask

  initial begin
    int nv;
    bit reached;
    for (int i = 0; i < 256; i++) mem[i] = OBSTACLE_VAL;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_cs", 32'(bus.cs), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_err", 32'(err), 32'd0);
    check_val("rst_len", 32'(path_len), 32'd0);
    check_val("rst_addr", 32'(bus.address), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Straight path with first-beat latency.
    fill(OBSTACLE_VAL);
    for (int i = 1; i <= 3; i++) mem[i] = PATH_VAL;
    ready_mode = 0;
    run_walk(0, 3, 0, 1'b1);

    // Turn with back-pressure; decoy cell 8 must never be read.
    fill(OBSTACLE_VAL);
    mem[15] = PATH_VAL; mem[23] = PATH_VAL; mem[8] = PATH_VAL;
    ready_mode = 2;
    run_walk(7, 23, 0, 1'b0);
    check_val("decoy_addr8", 32'(addr8_hits), 32'd0);

    // Dead end.
    fill(OBSTACLE_VAL);
    ready_mode = 0;
    run_walk(9, 63, 0, 1'b0);

    // Source equals target.
    run_walk(27, 27, 0, 1'b0);

    // start while busy is ignored.
    fill(OBSTACLE_VAL);
    for (int i = 1; i <= 3; i++) mem[i] = PATH_VAL;
    ready_mode = 1;
    run_walk(0, 3, 6, 1'b0);

    // Reset during the second EMIT, then a clean rerun.
    ready_mode = 0;
    mem[SRC_ADDR] = 8'd0; mem[TGT_ADDR] = 8'd3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    nv = 0; reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
      if (nv == 2) begin reset = 1'b0; reached = 1'b1; break; end
    end
    check_val("second_emit", 32'(reached), 32'd1);
    @(negedge clk);
    check_val("abort_valid", 32'(bus.out_valid), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_cs", 32'(bus.cs), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    run_walk(0, 3, 0, 1'b1);

    // Randomized maps, endpoints and consumer behaviour.
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 64; i++)
        mem[i] = ($urandom_range(0, 99) < 45) ? PATH_VAL : OBSTACLE_VAL;
      ready_mode = int'($urandom_range(0, 2));
      run_walk(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 0, 1'b0);
    end

    check_val("we_low", 32'(bus.we), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/route_walker.md
Name: route_walker

Overview:
- Downstream stage of the maze router. Starts when the router's done flag rises.
- Reads the routed 8x8 map back from the shared RAM (cells 0..63; path cells hold 0x00) plus source/target locations stored at fixed addresses.
- Walks the marked path from source to target and streams each cell's (x,y) coordinate over a valid/ready interface, then reports path length or an error.

Parameters:
- GRID_DIM, 8, cells per row/column; cell index = y*GRID_DIM + x.
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- SRC_ADDR, 130, RAM address holding the source cell index.
- TGT_ADDR, 131, RAM address holding the target cell index.
- PATH_VAL, 8'h00, map value marking a routed cell.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  begin walk; sampled only in IDLE (connect to router D).
- address  output  ADDR_WIDTH  RAM address.
- cs  output  1  RAM chip select.
- we  output  1  RAM write enable; always 0 (read-only block).
- data_in  input  DATA_WIDTH  RAM read data, valid the cycle after address/cs are presented.
- out_valid  output  1  coordinate valid.
- out_ready  input  1  consumer accepts coordinate.
- out_x  output  3  cell column.
- out_y  output  3  cell row.
- out_last  output  1  marks the target coordinate.
- busy  output  1  high outside IDLE.
- done  output  1  one-cycle pulse on successful completion.
- err  output  1  sticky until the next accepted start or reset; high when no continuation is found.
- path_len  output  7  number of coordinates emitted; valid when done pulses.

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs 0; visited vector cleared.
- Reset applied mid-walk aborts on the next edge; no further beats are emitted.
- States:
  - IDLE: start=1 -> RD_SRC. Clears err, path_len and visited.
  - RD_SRC: drive address=SRC_ADDR, cs=1. Next cycle, latch src = data_in[5:0] -> RD_TGT.
  - RD_TGT: same procedure with TGT_ADDR, latching tgt. Then cur=src, mark visited[src] -> EMIT.
  - EMIT: hold out_valid=1 with out_x=cur[2:0], out_y=cur[5:3], out_last=(cur==tgt).
    - On out_valid&&out_ready: path_len+1. If out_last -> DONE, else dir=E -> PROBE_REQ.
    - out_x/out_y/out_last stay stable while out_valid is high and out_ready is low.
  - PROBE_REQ: compute the neighbour for dir in fixed order E(+1), W(-1), S(+GRID_DIM), N(-GRID_DIM).
    - Skip the direction with no RAM access if the neighbour leaves the grid: E when x==7, W when x==0, S when y==7, N when y==0. No wrap-around between rows.
    - Also skip if the neighbour is already visited.
    - Otherwise issue address=neighbour, cs=1 -> PROBE_WAIT.
    - If all four directions are exhausted -> ERR.
  - PROBE_WAIT: the neighbour is accepted if data_in==PATH_VAL or neighbour==tgt.
    - Accepted: cur=neighbour, mark visited -> EMIT.
    - Rejected: advance dir -> PROBE_REQ.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: err=1 -> IDLE.
- Step limit: if path_len reaches 64 without out_last -> ERR.
- cs=0 in every state without a RAM access; address holds its last value.
- Latency: the first beat is valid 5 cycles after start. Each further beat takes 2–8 cycles (2 per probed direction) plus consumer stall.
- Source cell value is ignored (the router does not mark it). The target is accepted regardless of its value.
- If src==tgt: one beat with out_last=1, path_len=1, done.
- start while busy: ignored.

Decomposition:
- Shared package maze_pkg:
  - GRID_DIM, cell-index width (6), SRC_ADDR, TGT_ADDR, PATH_VAL, OBSTACLE_VAL (8'hee).
  - Direction encoding (E=0, W=1, S=2, N=3).
  - State encoding.
- One sub-module: neighbour_calc. Combinational: (cur, dir) -> (neighbour index, in_grid).

Test Plan:
- Straight path: src=0, tgt=3, cells 1..3=0x00, rest 0xee, out_ready=1 -> beats (0,0),(1,0),(2,0),(3,0), out_last on the 4th, path_len=4, done pulse, err=0.
- Turn plus back-pressure: src=7, tgt=23, cells 15,23=0x00, cell 8=0x00 (decoy). Hold out_ready=0 for 3 cycles per beat -> beats (7,0),(7,1),(7,2); outputs stable during stalls; cell 8 never addressed.
- Dead end: src=9, all neighbours 0xee, tgt=63 -> one beat (1,1), then err=1, no done, busy falls.
- src==tgt=27 -> single beat (3,3) with out_last=1, path_len=1.
- Reset low during the second EMIT of the straight-path case -> next cycle out_valid=0, busy=0, cs=0. A subsequent start reruns the walk cleanly, giving path_len=4.
- start pulsed again while busy -> ignored; beat sequence and path_len unchanged.
